// File: rtl/mem_model_pkg.sv
// Shared types and constants for the variable-latency memory model.
//   lat_mode_e  : LAT_FIXED uses per-op latencies, LAT_RANDOM draws the
//                 latency from a bounded window using a 16-bit LFSR.
//   mem_state_e : request FSM states (IDLE -> BUSY -> DONE -> IDLE).
//   LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10).
//   lfsr_next() : one Fibonacci shift step, feedback enters at bit 0.
package mem_model_pkg;

  typedef enum logic {
    LAT_FIXED,
    LAT_RANDOM
  } lat_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that free-runs every cycle out of reset.
//   clk   : clock
//   rst_n : synchronous active-low reset; loads the seed
//   seed  : reset value; an all-zero seed would lock up, so it becomes 1
//   q     : current LFSR state
module lfsr16
  import mem_model_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_eff;
  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
    q_d      = lfsr_next(q_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= seed_eff;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_vlat.sv
// Variable-latency single-port memory model with a level-request /
// ready-pulse handshake. One request is served at a time; the op, address,
// data and strobes are captured when the request is accepted.
//   clk   : clock
//   rst_n : synchronous active-low reset (storage is not cleared)
//   addr  : word address
//   wdata : write data
//   wstrb : byte enables, bit i covers byte i
//   write : write request (level)
//   read  : read request (level); read+write together is a write plus err
//   rdata : read data, held until the next read completes
//   ready : one-cycle completion pulse
//   err   : one-cycle pulse in the cycle right after a read+write capture
module mem_vlat
  import mem_model_pkg::*;
#(
  parameter int          DATA_WIDTH    = 32,
  parameter int          DEPTH         = 1024,
  parameter lat_mode_e   LAT_MODE      = LAT_FIXED,
  parameter int          READ_LATENCY  = 5,
  parameter int          WRITE_LATENCY = 5,
  parameter int          MIN_LAT       = 1,
  parameter int          MAX_LAT       = 8,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic                       write,
  input  logic                       read,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       ready,
  output logic                       err
);

  localparam int AW      = $clog2(DEPTH);
  localparam int NB      = DATA_WIDTH / 8;
  localparam int RD_LAT  = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam int WR_LAT  = (WRITE_LATENCY < 1) ? 1 : WRITE_LATENCY;
  localparam int FIX_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int MAX_L   = (MAX_LAT > FIX_MAX) ? MAX_LAT : FIX_MAX;
  localparam int CNT_W   = $clog2(MAX_L + 1);
  localparam int RANGE   = MAX_LAT - MIN_LAT + 1;
  // Keeps the modulo well-defined even while a bad window is being reported.
  localparam int RANGE_SAFE = (RANGE < 1) ? 1 : RANGE;

  if (MIN_LAT > MAX_LAT) begin : g_err_window
    $error("mem_vlat: MIN_LAT (%0d) exceeds MAX_LAT (%0d)", MIN_LAT, MAX_LAT);
  end
  if (LAT_MODE == LAT_RANDOM && MIN_LAT < 1) begin : g_err_min
    $error("mem_vlat: MIN_LAT must be at least 1");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_err_width
    $error("mem_vlat: DATA_WIDTH must be a multiple of 8");
  end
  if ((1 << AW) != DEPTH) begin : g_err_depth
    $error("mem_vlat: DEPTH must be a power of two");
  end

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         wstrb_q, wstrb_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [15:0]           lfsr_q;
  int                    lat;
  logic [CNT_W-1:0]      lat_m1;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  // Latency of a request presented this cycle; only used on capture.
  always_comb begin
    lat = RD_LAT;
    if (LAT_MODE == LAT_RANDOM) begin
      lat = MIN_LAT + (int'(lfsr_q) % RANGE_SAFE);
    end else if (write) begin
      lat = WR_LAT;
    end
    lat_m1 = CNT_W'(lat - 1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (read || write) begin
          is_wr_d = write;
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          err_d   = read && write;
          // A one-cycle latency skips BUSY so ready follows the capture edge.
          if (lat_m1 == '0) begin
            state_d = DONE;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = lat_m1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // The memory access happens on the edge that raises ready, using the
  // next-state capture values so the one-cycle path (IDLE -> DONE) works.
  always_ff @(posedge clk) begin
    if (rst_n && ready_d && is_wr_d) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_d[b]) begin
          mem_array[addr_d][b*8 +: 8] <= wdata_d[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (ready_d && !is_wr_d) begin
      rdata_q <= mem_array[addr_d];
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_vlat.sv
// Bench for mem_vlat: three instances (fixed latency 5, random 2..6, fixed
// latency 1) checked every cycle against a transaction-level model that
// predicts the absolute edge at which each request completes.
module tb_mem_vlat;
  import mem_model_pkg::*;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  addr_i  [NI];
  logic [31:0] wdata_i [NI];
  logic [3:0]  wstrb_i [NI];
  logic        wr_i    [NI];
  logic        rd_i    [NI];
  logic [31:0] rdata_o [NI];
  logic        ready_o [NI];
  logic        err_o   [NI];

  int n_cmp = 0;
  int n_bad = 0;

  mem_vlat #(.LAT_MODE(LAT_FIXED), .READ_LATENCY(5), .WRITE_LATENCY(5)) u_fix (
    .clk(clk), .rst_n(rst_n), .addr(addr_i[0]), .wdata(wdata_i[0]), .wstrb(wstrb_i[0]),
    .write(wr_i[0]), .read(rd_i[0]), .rdata(rdata_o[0]), .ready(ready_o[0]), .err(err_o[0]));

  mem_vlat #(.LAT_MODE(LAT_RANDOM), .MIN_LAT(2), .MAX_LAT(6), .SEED(16'hACE1)) u_rnd (
    .clk(clk), .rst_n(rst_n), .addr(addr_i[1]), .wdata(wdata_i[1]), .wstrb(wstrb_i[1]),
    .write(wr_i[1]), .read(rd_i[1]), .rdata(rdata_o[1]), .ready(ready_o[1]), .err(err_o[1]));

  mem_vlat #(.LAT_MODE(LAT_FIXED), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_one (
    .clk(clk), .rst_n(rst_n), .addr(addr_i[2]), .wdata(wdata_i[2]), .wstrb(wstrb_i[2]),
    .write(wr_i[2]), .read(rd_i[2]), .rdata(rdata_o[2]), .ready(ready_o[2]), .err(err_o[2]));

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int model_lat(input int k, input logic [15:0] lf);
    if (k == 0) return 5;
    if (k == 2) return 1;
    return 2 + (int'(lf) % 5);
  endfunction

  int          edge_n = 0;
  bit          m_busy  [NI];
  bit          m_gap   [NI];
  int          m_done  [NI];
  bit          m_is_wr [NI];
  int          m_addr  [NI];
  logic [31:0] m_wd    [NI];
  logic [3:0]  m_ws    [NI];
  logic [15:0] m_lfsr  [NI];
  logic [31:0] m_mem   [NI][1024];
  bit          e_ready [NI];
  bit          e_err   [NI];
  logic [31:0] e_rdata [NI];

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_gap[k] = 0;
        e_ready[k] = 0; e_err[k] = 0; e_rdata[k] = 32'h0;
        m_lfsr[k] = 16'hACE1;
      end else begin
        e_ready[k] = 0;
        e_err[k]   = 0;
        if (m_gap[k]) begin
          m_gap[k] = 0;
        end else if (!m_busy[k] && (rd_i[k] || wr_i[k])) begin
          m_busy[k]  = 1;
          m_is_wr[k] = wr_i[k];
          m_addr[k]  = int'(addr_i[k]);
          m_wd[k]    = wdata_i[k];
          m_ws[k]    = wstrb_i[k];
          e_err[k]   = rd_i[k] && wr_i[k];
          m_done[k]  = edge_n + model_lat(k, m_lfsr[k]) - 1;
        end
        if (m_busy[k] && edge_n == m_done[k]) begin
          e_ready[k] = 1;
          m_busy[k]  = 0;
          m_gap[k]   = 1;
          if (m_is_wr[k]) begin
            for (int b = 0; b < 4; b++)
              if (m_ws[k][b]) m_mem[k][m_addr[k]][b*8 +: 8] = m_wd[k][b*8 +: 8];
          end else begin
            e_rdata[k] = m_mem[k][m_addr[k]];
          end
        end
        m_lfsr[k] = lfsr_step(m_lfsr[k]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (edge_n > 0) begin
      for (int k = 0; k < NI; k++) begin
        n_cmp += 3;
        if (ready_o[k] !== e_ready[k]) begin
          n_bad++;
          $display("FAIL ready[%0d] @edge %0d: got %b expected %b", k, edge_n, ready_o[k], e_ready[k]);
        end
        if (err_o[k] !== e_err[k]) begin
          n_bad++;
          $display("FAIL err[%0d] @edge %0d: got %b expected %b", k, edge_n, err_o[k], e_err[k]);
        end
        if (rdata_o[k] !== e_rdata[k]) begin
          n_bad++;
          $display("FAIL rdata[%0d] @edge %0d: got %h expected %h", k, edge_n, rdata_o[k], e_rdata[k]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic txn(input int k, input bit rd, input bit wr, input int a,
                     input logic [31:0] wd, input logic [3:0] ws,
                     output int lat, output bit err_first);
    rd_i[k] = rd; wr_i[k] = wr; addr_i[k] = 10'(a); wdata_i[k] = wd; wstrb_i[k] = ws;
    lat = 0;
    err_first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) err_first = err_o[k];
      if (ready_o[k]) begin
        lat = c;
        break;
      end
    end
    rd_i[k] = 0; wr_i[k] = 0;
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout[%0d]: got no ready within 40 cycles, expected ready", k);
    end
    @(negedge clk);
  endtask

  int lat, seq_a [100];
  bit errf;
  bit [6:0] seen;

  initial begin
    rst_n = 0;
    for (int k = 0; k < NI; k++) begin
      addr_i[k] = '0; wdata_i[k] = '0; wstrb_i[k] = '0; wr_i[k] = 0; rd_i[k] = 0;
    end
    for (int i = 0; i < 1024; i++) begin
      u_fix.mem_array[i] = 32'h0;                  m_mem[0][i] = 32'h0;
      u_rnd.mem_array[i] = 32'(i) * 32'h01010101;  m_mem[1][i] = 32'(i) * 32'h01010101;
      u_one.mem_array[i] = 32'h0;                  m_mem[2][i] = 32'h0;
    end
    u_fix.mem_array[3] = 32'h1234_5678;  m_mem[0][3] = 32'h1234_5678;
    u_fix.mem_array[9] = 32'h1111_1111;  m_mem[0][9] = 32'h1111_1111;
    u_one.mem_array[5] = 32'hA5A5_5A5A;  m_mem[2][5] = 32'hA5A5_5A5A;

    chk("lfsr_step_ACE1", 32'(lfsr_step(16'hACE1)), 32'h0000_59C3);

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(ready_o[0]), 32'h0);
    chk("reset_rdata", rdata_o[0], 32'h0);
    rst_n = 1;
    @(negedge clk);

    // Fixed latency 5 read of a preloaded word.
    txn(0, 1, 0, 3, 32'h0, 4'h0, lat, errf);
    chk("fix_read_lat", 32'(lat), 32'd5);
    chk("fix_read_data", rdata_o[0], 32'h1234_5678);
    chk("fix_read_err", 32'(errf), 32'h0);

    // Partial-strobe write, then read back.
    txn(0, 0, 1, 7, 32'hdeadbeef, 4'b0101, lat, errf);
    chk("fix_write_lat", 32'(lat), 32'd5);
    chk("fix_write_mem7", u_fix.mem_array[7], 32'h00ad00ef);
    txn(0, 1, 0, 7, 32'h0, 4'h0, lat, errf);
    chk("fix_readback7", rdata_o[0], 32'h00ad00ef);

    // Read and write together: treated as write, err pulse, rdata unchanged.
    txn(0, 1, 1, 12, 32'hcafe0000, 4'hF, lat, errf);
    chk("dual_err_pulse", 32'(errf), 32'h1);
    chk("dual_rdata_kept", rdata_o[0], 32'h00ad00ef);
    txn(0, 1, 0, 12, 32'h0, 4'h0, lat, errf);
    chk("dual_readback", rdata_o[0], 32'hcafe0000);

    // Reset during BUSY of a write to addr 9: aborted, no commit.
    rd_i[0] = 0; wr_i[0] = 1; addr_i[0] = 10'd9; wdata_i[0] = 32'hFFFF0000; wstrb_i[0] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 0; wr_i[0] = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_ready", 32'(ready_o[0]), 32'h0);
    chk("abort_rdata", rdata_o[0], 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_mem9", u_fix.mem_array[9], 32'h1111_1111);
    txn(0, 1, 0, 9, 32'h0, 4'h0, lat, errf);
    chk("abort_next_lat", 32'(lat), 32'd5);
    chk("abort_next_data", rdata_o[0], 32'h1111_1111);

    // Latency 1, read held high across three transactions.
    addr_i[2] = 10'd5; rd_i[2] = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("held_ready_c%0d", c), 32'(ready_o[2]), (c % 2 == 0) ? 32'h1 : 32'h0);
    end
    rd_i[2] = 0;
    @(negedge clk);
    chk("held_rdata", rdata_o[2], 32'hA5A5_5A5A);

    // Top address DEPTH-1 with latency 1.
    txn(2, 0, 1, 1023, 32'h0badf00d, 4'hF, lat, errf);
    chk("top_write_lat", 32'(lat), 32'd1);
    txn(2, 1, 0, 1023, 32'h0, 4'h0, lat, errf);
    chk("top_read_lat", 32'(lat), 32'd1);
    chk("top_read_data", rdata_o[2], 32'h0badf00d);

    // Random latency window, run twice from the same reset point.
    seen = '0;
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 100; i++) begin
        txn(1, 1, 0, (i * 37) % 1024, 32'h0, 4'h0, lat, errf);
        n_cmp++;
        if (lat < 2 || lat > 6) begin
          n_bad++;
          $display("FAIL rnd_range #%0d: got latency %0d, required 2..6", i, lat);
        end else begin
          seen[lat] = 1'b1;
        end
        if (pass == 0) begin
          seq_a[i] = lat;
        end else begin
          n_cmp++;
          if (lat != seq_a[i]) begin
            n_bad++;
            $display("FAIL rnd_repeat #%0d: got latency %0d expected %0d", i, lat, seq_a[i]);
          end
        end
      end
      $display("ok   random pass %0d done", pass);
    end
    chk("rnd_all_seen", 32'(seen[6:2]), 32'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_vlat.md
# mem_vlat

Parametrised variable-latency single-port memory model, the successor to the fixed-latency bench memory used behind the stall-for-memory pipelined core. It serves one request at a time over the core's level-request / ready-pulse handshake, so it can back either the instruction port or the data port. Latency is either fixed per access type or pseudo-random in a bounded window, which stress-tests core stall logic. Storage is a plain array named `mem_array` so benches can preload and dump it with `$readmemh`/`$writememh`.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8
- DEPTH, 1024, words; power of two
- LAT_MODE, LAT_FIXED, `lat_mode_e`: LAT_FIXED or LAT_RANDOM
- READ_LATENCY, 5, read latency in LAT_FIXED; values <1 are treated as 1
- WRITE_LATENCY, 5, write latency in LAT_FIXED; values <1 are treated as 1
- MIN_LAT, 1, lower bound in LAT_RANDOM; must be ≥1
- MAX_LAT, 8, upper bound in LAT_RANDOM; MIN_LAT>MAX_LAT is an elaboration error
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- addr  in  $clog2(DEPTH)  word address
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables; bit i covers byte i
- write  in  1  write request (level)
- read  in  1  read request (level)
- rdata  out  DATA_WIDTH  read data
- ready  out  1  single-cycle completion pulse
- err  out  1  single-cycle pulse when read and write are sampled together

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - BUSY: counting down latency.
  - DONE: ready cycle.
- IDLE → BUSY when read or write is high. The op type, addr, wdata and wstrb are captured into registers; later input changes are ignored.
- Read and write high together: treated as a write, and err pulses in the capture cycle.
- Latency L:
  - LAT_FIXED: READ_LATENCY or WRITE_LATENCY, per op.
  - LAT_RANDOM: MIN_LAT + (lfsr mod (MAX_LAT−MIN_LAT+1)), computed in the capture cycle.
- Counter loads L−1. BUSY decrements the counter; when it reaches 0 → DONE.
- DONE: ready=1 for exactly one cycle.
  - Write: bytes with wstrb=1 are committed to mem_array[addr]; other bytes are unchanged. rdata is unchanged.
  - Read: rdata = mem_array[addr], held until the next read completes.
  - Then → IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle while rst_n=1.
- Arithmetic: counter width $clog2(max latency + 1). The mod is computed on the full 16-bit LFSR value.

## Timing
- A request sampled at rising edge t in IDLE gives ready high in the cycle following edge t+L−1, i.e. ready is seen at edge t+L. L=1 means ready is seen at edge t+1.
- IDLE is always at least one cycle between transactions. A request still high in the cycle after ready is taken as a new request.
- Reset values: ready=0, err=0, rdata=0, state=IDLE, counter=0, lfsr=SEED.
- mem_array is not affected by reset.
- Reset asserted mid-transaction: the transaction is aborted, with no write commit and no ready.
- A read of an address written by the preceding transaction returns the new data.
- An address exactly DEPTH−1 is legal. There is no wrap and no out-of-range case, because addr width equals $clog2(DEPTH).

## Structure
- Package `mem_model_pkg`:
  - `lat_mode_e`
  - `mem_state_e` {IDLE, BUSY, DONE}
  - LFSR tap constant
- Sub-module `lfsr16`: ports clk, rst_n, seed, q.
- `mem_vlat` itself holds the FSM, counter, capture registers and mem_array.

## Test plan
- LAT_FIXED, READ_LATENCY=5: mem[3]=32'h1234_5678 preloaded; read addr 3 held until ready → ready exactly 5 edges after capture, rdata=32'h1234_5678, err=0.
- Write addr 7, wdata 32'hdeadbeef, wstrb 4'b0101, prior mem[7]=0 → after ready, mem[7]=32'h00ad00ef. A following read returns the same value.
- LAT_RANDOM, MIN_LAT=2, MAX_LAT=6, 200 reads → every latency in [2,6], all five values seen, sequence reproducible for the same SEED.
- read=1 and write=1 together, wdata 32'hcafe0000, wstrb 4'hF → err pulse in the capture cycle, write committed, rdata unchanged.
- rst_n low for one cycle during BUSY of a write to addr 9 → no ready, mem[9] unchanged, outputs at reset values. A read issued next completes with fresh latency.
- read held high continuously for 3 transactions, LAT_FIXED latency 1 → ready pulses every 2 cycles, one IDLE cycle between transactions.
